// File: rtl/bcd_countdown_timer.sv
// Three-decade BCD down-counter with load, start/pause and expiry pulse.
// Optional auto-reload turns it into a periodic tick divider.
module bcd_countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_ones,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_hundreds,
  input  logic       start,
  input  logic       pause,
  input  logic       enable,
  output logic [3:0] onesplace,
  output logic [3:0] tensplace,
  output logic [3:0] hundredsplace,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] hund_q, hund_d;
  logic [3:0] rl_ones_q, rl_ones_d;
  logic [3:0] rl_tens_q, rl_tens_d;
  logic [3:0] rl_hund_q, rl_hund_d;
  logic       run_q;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [3:0] c_ones, c_tens, c_hund;
  logic       clamp;
  logic       is_zero, is_one;
  logic [3:0] dec_ones, dec_tens, dec_hund;

  // Clamp load digits and precompute the borrow-rippled decrement
  always_comb begin
    c_ones  = (load_ones > 4'd9) ? 4'd9 : load_ones;
    c_tens  = (load_tens > 4'd9) ? 4'd9 : load_tens;
    c_hund  = (load_hundreds > 4'd9) ? 4'd9 : load_hundreds;
    clamp   = (load_ones > 4'd9) | (load_tens > 4'd9)
            | (load_hundreds > 4'd9);
    is_zero = (ones_q == 4'd0) & (tens_q == 4'd0) & (hund_q == 4'd0);
    is_one  = (ones_q == 4'd1) & (tens_q == 4'd0) & (hund_q == 4'd0);
    dec_ones = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
    dec_tens = tens_q;
    dec_hund = hund_q;
    if (ones_q == 4'd0) begin
      dec_tens = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
      if (tens_q == 4'd0) begin
        dec_hund = (hund_q == 4'd0) ? 4'd0 : hund_q - 4'd1;
      end
    end
  end

  // Next-state: load > pause > start > enable decrement
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    hund_d    = hund_q;
    rl_ones_d = rl_ones_q;
    rl_tens_d = rl_tens_q;
    rl_hund_d = rl_hund_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (load) begin
      ones_d    = c_ones;
      tens_d    = c_tens;
      hund_d    = c_hund;
      rl_ones_d = c_ones;
      rl_tens_d = c_tens;
      rl_hund_d = c_hund;
      state_d   = IDLE;
      err_d     = clamp;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !is_zero) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (enable) begin
            if (is_one) begin
              done_d = 1'b1;
              if (AUTO_RELOAD) begin
                ones_d = rl_ones_q;
                tens_d = rl_tens_q;
                hund_d = rl_hund_q;
              end else begin
                ones_d  = 4'd0;
                tens_d  = 4'd0;
                hund_d  = 4'd0;
                state_d = IDLE;
              end
            end else begin
              ones_d = dec_ones;
              tens_d = dec_tens;
              hund_d = dec_hund;
            end
          end
        end
        HOLD: begin
          if (start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, digit and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      hund_q    <= 4'd0;
      rl_ones_q <= 4'd0;
      rl_tens_q <= 4'd0;
      rl_hund_q <= 4'd0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      hund_q    <= hund_d;
      rl_ones_q <= rl_ones_d;
      rl_tens_q <= rl_tens_d;
      rl_hund_q <= rl_hund_d;
      run_q     <= (state_d == RUN);
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign onesplace     = ones_q;
  assign tensplace     = tens_q;
  assign hundredsplace = hund_q;
  assign running       = run_q;
  assign done          = done_q;
  assign load_err      = err_q;

endmodule
